sram_port_ctrl: RTL
===================

# sram_port_ctrl

Synchronous initiator for the read/write port of the BURP dual-port SRAM. Converts single-word processor requests (req/ready handshake) into the SRAM's strobe sequence: active-low chip enable, active-high output enable, rw (1 = read, 0 = write), a 4-bit address and a shared tri-state data bus. It owns bus turnaround, so the controller and the SRAM never drive the data bus at the same time. Sits between the core's load/store unit and the SRAM's read/write port.

## Interface
- ADDR_W, 4, address width
- DATA_W, 8, data width
- ACCESS_CYC, 2, cycles ce_n stays asserted per access (legal range 1..15)

- clk  in  1  system clock; all logic rises on posedge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request; accepted on a clk edge where req && ready
- we  in  1  1 = write, 0 = read; sampled at accept
- addr  in  ADDR_W  word address; sampled at accept
- wdata  in  DATA_W  write data; sampled at accept
- ready  out  1  high only in IDLE
- rdata  out  DATA_W  read data; holds its value until the next read completes
- rvalid  out  1  one-cycle pulse when rdata is updated
- wr_err  out  1  write-verify mismatch pulse (see Configuration)
- sram_ce_n  out  1  SRAM chip enable, active low
- sram_oe  out  1  SRAM output enable, active high
- sram_rw  out  1  1 = read, 0 = write
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  shared data bus; driven only while drive_en=1, otherwise Z

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD (plus VERIFY_SETUP, VERIFY_ACCESS, VERIFY_HOLD when the verify feature is compiled in). All outputs are registered.
- IDLE: ready=1, ce_n=1, oe=0, rw=1, drive_en=0. On req: latch we, addr and wdata, then go to SETUP.
- SETUP (1 cycle): sram_addr=latched address, ce_n=1. Write: drive_en=1, oe=0. Read: drive_en=0, oe=0.
- ACCESS (ACCESS_CYC cycles, down-counter): ce_n=0. Write: rw=0, drive_en=1, oe=0. Read: rw=1, oe=1, drive_en=0. On a read, sram_data is captured into a holding register on the last ACCESS cycle.
- HOLD (1 cycle): ce_n=1, rw=1, oe=0. On a write, drive_en stays 1 so data holds past the rw rising edge. On a read, rdata is updated and rvalid=1. Next state is IDLE.
- Invariant: oe=1 and drive_en=1 never occur together. rw=0 only while ce_n=0. sram_addr is stable from SETUP through HOLD.
- req while ready=0 is ignored. The requester holds req until it is accepted.
- Counter is 4 bits and reloads to ACCESS_CYC-1 on entry to ACCESS. It never wraps.

## Timing
- Reset (async assert, sync release) values: ready=1, ce_n=1, oe=0, rw=1, sram_addr=0, drive_en=0 (bus Z), rdata=0, rvalid=0, wr_err=0, state IDLE.
- Reset asserted mid-transfer: strobes go inactive and the bus is released immediately. The transfer is dropped with no rvalid and no wr_err.
- Read latency: accept at edge 0, SETUP in cycle 1, ACCESS in cycles 2..1+ACCESS_CYC, rvalid in cycle 2+ACCESS_CYC, ready in cycle 3+ACCESS_CYC.
- Write occupancy: 3+ACCESS_CYC cycles from accept to ready.
- Back-to-back transfers: one IDLE cycle minimum between transfers. Throughput is one transfer per 3+ACCESS_CYC cycles (5 cycles at the default).

## Configuration
- SRAM_CTRL_VERIFY_EN defined: after a write's HOLD, the FSM performs a read of the same address through VERIFY_SETUP, VERIFY_ACCESS and VERIFY_HOLD, using the same timing as a read. If the captured data differs from the latched wdata, wr_err pulses for one cycle in VERIFY_HOLD. rvalid does not pulse and rdata is unchanged. Write occupancy becomes 2×(2+ACCESS_CYC)+1 cycles.
- Not defined: the verify states are absent, wr_err is tied to 0, and write timing is as listed under Timing.

## Test plan
- Reset mid-write (rst_n low during ACCESS) -> ce_n=1, rw=1, oe=0, and sram_data is Z in the same cycle; ready=1 after release; the SRAM word is unchanged.
- Read addr 2 from the SRAM model preloaded with mem[0..4]=1..5, ACCESS_CYC=2 -> rvalid in cycle 4 after accept with rdata=8'h03; oe is high only in cycles 2–3.
- Write addr 9 with 8'hA5, then read addr 9 -> rdata=8'hA5; rw=0 only while ce_n=0; the bus checker flags no cycle with oe && drive_en.
- req held high continuously with alternating writes and reads -> accepts are exactly 5 cycles apart; requests arriving while busy are ignored and not lost.
- SRAM_CTRL_VERIFY_EN with the model forced to corrupt bit 0 on a write of 8'h3C to addr 1 -> wr_err pulses once, no rvalid, ready returns 9 cycles after accept. Without the macro -> wr_err stays 0 and ready returns in 5 cycles.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: turns single-word req/ready transfers into the BURP SRAM strobe sequence.
// Optional write read-back verify is compiled in with `define SRAM_CTRL_VERIFY_EN.
module sram_port_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wr_err,
    output logic              sram_ce_n,
    output logic              sram_oe,
    output logic              sram_rw,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
`ifdef SRAM_CTRL_VERIFY_EN
        , S_VSETUP,
        S_VACCESS,
        S_VHOLD
`endif
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

    state_t              state;
    state_t              next_state;
    logic [3:0]          cnt;
    logic                cnt_last;
    logic                accept;
    logic                we_q;
    logic                we_n;
    logic [DATA_W-1:0]   wdata_q;
    logic                drive_en;

    logic                ready_d;
    logic                ce_n_d;
    logic                oe_d;
    logic                rw_d;
    logic                drive_d;
    logic                rvalid_d;

    assign accept   = (state == S_IDLE) && req;
    assign cnt_last = (cnt == 4'd0);

    // The controller only ever drives the bus with the latched write data.
    assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

    // State register and access down-counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            case (state)
`ifdef SRAM_CTRL_VERIFY_EN
                S_SETUP, S_VSETUP:   cnt <= CNT_LOAD;
                S_ACCESS, S_VACCESS: if (!cnt_last) cnt <= cnt - 4'd1;
`else
                S_SETUP:             cnt <= CNT_LOAD;
                S_ACCESS:            if (!cnt_last) cnt <= cnt - 4'd1;
`endif
                default:             cnt <= cnt;
            endcase
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (req) next_state = S_SETUP;
            S_SETUP:  next_state = S_ACCESS;
            S_ACCESS: if (cnt_last) next_state = S_HOLD;
`ifdef SRAM_CTRL_VERIFY_EN
            S_HOLD:    next_state = we_q ? S_VSETUP : S_IDLE;
            S_VSETUP:  next_state = S_VACCESS;
            S_VACCESS: if (cnt_last) next_state = S_VHOLD;
            S_VHOLD:   next_state = S_IDLE;
`else
            S_HOLD:    next_state = S_IDLE;
`endif
            default:   next_state = S_IDLE;
        endcase
    end

    // Output decode from the state being entered; the results are registered below
    // so the strobes change exactly with the state register.
    always_comb begin
        we_n     = accept ? we : we_q;
        ready_d  = 1'b0;
        ce_n_d   = 1'b1;
        oe_d     = 1'b0;
        rw_d     = 1'b1;
        drive_d  = 1'b0;
        rvalid_d = 1'b0;
        case (next_state)
            S_IDLE:   ready_d = 1'b1;
            S_SETUP:  drive_d = we_n;
            S_ACCESS: begin
                ce_n_d  = 1'b0;
                rw_d    = ~we_n;
                oe_d    = ~we_n;
                drive_d = we_n;
            end
            // Write data is held one cycle past the rw rising edge.
            S_HOLD: begin
                drive_d  = we_n;
                rvalid_d = ~we_n;
            end
`ifdef SRAM_CTRL_VERIFY_EN
            S_VACCESS: begin
                ce_n_d = 1'b0;
                oe_d   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Request latch: address stays stable from SETUP through the end of the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            wdata_q   <= '0;
            sram_addr <= '0;
        end else if (accept) begin
            we_q      <= we;
            wdata_q   <= wdata;
            sram_addr <= addr;
        end
    end

    // Registered outputs; async reset drops the strobes and releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready     <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe   <= 1'b0;
            sram_rw   <= 1'b1;
            drive_en  <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            ready     <= ready_d;
            sram_ce_n <= ce_n_d;
            sram_oe   <= oe_d;
            sram_rw   <= rw_d;
            drive_en  <= drive_d;
            rvalid    <= rvalid_d;
            if (state == S_ACCESS && cnt_last && !we_q) rdata <= sram_data;
        end
    end

`ifdef SRAM_CTRL_VERIFY_EN
    // Read-back compare happens on the last verify access cycle; rdata is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= (state == S_VACCESS) && cnt_last && (sram_data != wdata_q);
        end
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule
